// File: rtl/sobel_frame_writer_pkg.sv
// sobel_pkg: shared types and constants for the Sobel frame writer.
//   MEM_DATA_W / BYTES_PER_WORD / BE_W : memory word geometry
//   wr_state_e                         : writer FSM states
//   fifo_entry_t                       : one queued memory write (addr, data, be)
// The entry address field is sized for the widest supported ADDR_W (32);
// the writer zero-extends its address into it.
package sobel_pkg;
  localparam int MEM_DATA_W     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BE_W           = 4;
  localparam int ENTRY_ADDR_W   = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } wr_state_e;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0]   data;
    logic [BE_W-1:0]         be;
  } fifo_entry_t;
endpackage

// File: rtl/sobel_frame_writer_fifo.sv
// sobel_wr_fifo: synchronous show-ahead FIFO.
//   clk, rst (sync, active low)
//   push_i/din_i : write; accepted when not full, or when full with a pop
//   pop_i        : remove head; ignored when empty
//   dout_o       : head entry; holds the last popped entry while empty
//   full_o/empty_o : registered occupancy flags
module sobel_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // When full, a same-edge pop frees the head slot, which is also the tail slot.
  assign do_push = push_i && (!full_o || do_pop);
  // Outputs stay on the last written entry once the queue drains.
  assign dout_o  = empty_o ? last_q : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/sobel_frame_writer.sv
// sobel_frame_writer: packs the Sobel magnitude stream 4 pixels/word and
// writes words to a frame buffer via a req/ready port through a small FIFO.
//   clk, rst (sync, active low)
//   start, image_width, image_height, base_addr : frame arm, sampled in IDLE
//   pix_valid, pix_data : input stream, no backpressure
//   mem_req/mem_addr/mem_wdata/mem_be, mem_ready : write port (FIFO head)
//   busy, frame_done, overflow : status
// Optional: define SOBEL_WRITER_THRESH_EN to add threshold[7:0]; pixels are
// then binarised to 8'hFF / 8'h00 against the threshold sampled at start.
module sobel_frame_writer
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH  = 4096,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_WIDTH)-1:0] image_width,
  input  logic [15:0]                  image_height,
  input  logic [ADDR_W-1:0]            base_addr,
`ifdef SOBEL_WRITER_THRESH_EN
  input  logic [7:0]                   threshold,
`endif
  input  logic                         pix_valid,
  input  logic [7:0]                   pix_data,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [MEM_DATA_W-1:0]        mem_wdata,
  output logic [BE_W-1:0]              mem_be,
  input  logic                         mem_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overflow
);
  localparam int WW = $clog2(MAX_WIDTH);
  localparam int EW = $bits(fifo_entry_t);

  wr_state_e             state_q;
  logic [27:0]           n_q, cnt_q, n_calc;
  logic [ADDR_W-1:0]     addr_q;
  logic [MEM_DATA_W-1:0] word_q, word_nxt;
  logic [BE_W-1:0]       be_nxt;
  logic                  busy_q, done_q, ovf_q;
  logic [1:0]            lane;
  logic [7:0]            pix_byte;
  logic                  accept, last, push, pop, f_full, f_empty;
  fifo_entry_t           din, dout;
  logic [EW-1:0]         dout_bits;
  logic                  unused_addr_hi;

  // Output frame extent; degenerate images produce an empty frame.
  always_comb begin
    n_calc = '0;
    if (image_width >= WW'(3) && image_height >= 16'd3)
      n_calc = 28'(image_width - WW'(2)) * 28'(image_height - 16'd2);
  end

`ifdef SOBEL_WRITER_THRESH_EN
  logic [7:0] thr_q;
  always_ff @(posedge clk) begin
    if (!rst)                              thr_q <= '0;
    else if (state_q == S_IDLE && start)   thr_q <= threshold;
  end
  assign pix_byte = (pix_data >= thr_q) ? 8'hFF : 8'h00;
`else
  assign pix_byte = pix_data;
`endif

  assign lane   = cnt_q[1:0];
  assign accept = (state_q == S_RUN) && pix_valid;
  assign last   = (cnt_q + 28'd1 == n_q);
  assign push   = accept && (lane == 2'd3 || last);
  assign pop    = mem_req && mem_ready;

  always_comb begin
    word_nxt = word_q;
    word_nxt[lane*8 +: 8] = pix_byte;
    case (lane)
      2'd0:    be_nxt = 4'b0001;
      2'd1:    be_nxt = 4'b0011;
      2'd2:    be_nxt = 4'b0111;
      default: be_nxt = 4'b1111;
    endcase
  end

  always_comb begin
    din      = '0;
    din.addr = ENTRY_ADDR_W'(addr_q);
    din.data = word_nxt;
    din.be   = be_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // Dropped word: FIFO full and nothing leaving on this edge.
      if (push && f_full && !pop) ovf_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (n_calc != '0) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              n_q     <= n_calc;
              cnt_q   <= '0;
              addr_q  <= base_addr;
              word_q  <= '0;
              ovf_q   <= 1'b0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            cnt_q  <= cnt_q + 28'd1;
            word_q <= push ? '0 : word_nxt;
            // Address advances even on a dropped word to keep later ones aligned.
            if (push) addr_q <= addr_q + 1'b1;
            if (last) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (f_empty) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  sobel_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (dout_bits),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign dout           = dout_bits;
  assign unused_addr_hi = ^dout.addr;
  assign mem_req        = !f_empty;
  assign mem_addr       = dout.addr[ADDR_W-1:0];
  assign mem_wdata      = dout.data;
  assign mem_be         = dout.be;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_sobel_frame_writer.sv
module tb_sobel_frame_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] image_width = '0;
  logic [15:0] image_height = '0;
  logic [19:0] base_addr = '0;
`ifdef SOBEL_WRITER_THRESH_EN
  logic [7:0]  threshold = '0;
`endif
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic        busy, frame_done, overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wr_cyc = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_be[$];

  sobel_frame_writer dut (
    .clk(clk), .rst(rst), .start(start),
    .image_width(image_width), .image_height(image_height), .base_addr(base_addr),
`ifdef SOBEL_WRITER_THRESH_EN
    .threshold(threshold),
`endif
    .pix_valid(pix_valid), .pix_data(pix_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change at posedge+1, so negedge sees what the next posedge will sample.
  always @(negedge clk) begin
    if (rst && mem_req && mem_ready) begin
      wq_addr.push_back({12'h0, mem_addr});
      wq_data.push_back(mem_wdata);
      wq_be.push_back(mem_be);
      wr_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_q();
    wq_addr.delete();
    wq_data.delete();
    wq_be.delete();
  endtask

  task automatic arm(input logic [11:0] w, input logic [15:0] h, input logic [19:0] b);
    image_width = w; image_height = h; base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 3000) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cnt > prev), 32'd1);
    repeat (3) tick();
  endtask

  // Expect n full words with incrementing pixel bytes starting at 0.
  task automatic chk_words(input string tag, input int n, input logic [31:0] base);
    chk({tag, "_nwr"}, 32'(wq_addr.size()), 32'(n));
    for (int k = 0; k < n && k < wq_addr.size(); k++) begin
      chk({tag, "_addr"}, wq_addr[k], base + 32'(k));
      chk({tag, "_data"}, wq_data[k],
          {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
      chk({tag, "_be"}, 32'(wq_be[k]), 32'hF);
    end
  endtask

  initial begin
    int d0;
    // reset state
    repeat (2) tick();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b1;
    tick();

    // 6x6: four full words
    clr_q(); d0 = done_cnt; mem_ready = 1'b1;
    arm(12'd6, 16'd6, 20'h100);
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin pix_valid = 1'b1; pix_data = 8'(i); tick(); end
    pix_valid = 1'b0;
    wait_done(d0);
    chk_words("t1", 4, 32'h100);
    chk("t1_ndone", 32'(done_cnt - d0), 1);
    chk("t1_ovf", 32'(overflow), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // 5x5: partial last word
    clr_q(); d0 = done_cnt;
    arm(12'd5, 16'd5, 20'h200);
    for (int i = 0; i < 9; i++) begin pix_valid = 1'b1; pix_data = 8'(i); tick(); end
    pix_valid = 1'b0;
    wait_done(d0);
    chk("t2_nwr", 32'(wq_addr.size()), 3);
    if (wq_addr.size() == 3) begin
      chk("t2_d0", wq_data[0], 32'h03020100);
      chk("t2_d1", wq_data[1], 32'h07060504);
      chk("t2_d2", wq_data[2], 32'h00000008);
      chk("t2_be2", 32'(wq_be[2]), 32'h1);
      chk("t2_a2", wq_addr[2], 32'h202);
    end
    chk("t2_done_after_wr", 32'(done_cyc > wr_cyc), 1);

    // 10x10 with memory stalled: 8 kept, 8 dropped
    clr_q(); d0 = done_cnt; mem_ready = 1'b0;
    arm(12'd10, 16'd10, 20'h300);
    for (int i = 0; i < 64; i++) begin pix_valid = 1'b1; pix_data = 8'(i); tick(); end
    pix_valid = 1'b0;
    tick();
    chk("t3_ovf_stream", 32'(overflow), 1);
    chk("t3_busy_stall", 32'(busy), 1);
    mem_ready = 1'b1;
    wait_done(d0);
    chk_words("t3", 8, 32'h300);
    chk("t3_ovf_sticky", 32'(overflow), 1);

    // full FIFO with a pop on the same edge as the 9th push
    clr_q(); d0 = done_cnt; mem_ready = 1'b0;
    arm(12'd10, 16'd10, 20'h400);
    chk("t4_ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 64; i++) begin
      mem_ready = (i >= 35);
      pix_valid = 1'b1; pix_data = 8'(i); tick();
    end
    pix_valid = 1'b0;
    wait_done(d0);
    chk_words("t4", 16, 32'h400);
    chk("t4_ovf", 32'(overflow), 0);

    // reset mid-frame
    clr_q(); d0 = done_cnt; mem_ready = 1'b0;
    arm(12'd6, 16'd6, 20'h500);
    for (int i = 0; i < 5; i++) begin pix_valid = 1'b1; pix_data = 8'(i); tick(); end
    pix_valid = 1'b0;
    chk("t5_req_pre", 32'(mem_req), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t5_req", 32'(mem_req), 0);
    chk("t5_busy", 32'(busy), 0);
    repeat (10) tick();
    chk("t5_nodone", 32'(done_cnt - d0), 0);
    clr_q(); mem_ready = 1'b1;
    arm(12'd6, 16'd6, 20'h600);
    for (int i = 0; i < 16; i++) begin pix_valid = 1'b1; pix_data = 8'(i); tick(); end
    pix_valid = 1'b0;
    wait_done(d0);
    chk_words("t5", 4, 32'h600);

    // empty frame, then a start pulse during RUN that must be ignored
    clr_q(); d0 = done_cnt;
    arm(12'd2, 16'd100, 20'h700);
    tick(); tick();
    chk("t6_ndone", 32'(done_cnt - d0), 1);
    chk("t6_nwr", 32'(wq_addr.size()), 0);
    chk("t6_busy", 32'(busy), 0);
    d0 = done_cnt;
    arm(12'd6, 16'd6, 20'h710);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        start = 1'b1; image_width = 12'd5; image_height = 16'd5; base_addr = 20'h7F0;
      end else begin
        start = 1'b0;
      end
      pix_valid = 1'b1; pix_data = 8'(i); tick();
    end
    start = 1'b0; pix_valid = 1'b0;
    wait_done(d0);
    chk_words("t6b", 4, 32'h710);
    chk("t6b_ndone", 32'(done_cnt - d0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sobel_frame_writer.md
Name: sobel_frame_writer

Overview:
Sink for the Sobel engine's output stream. Takes the raw valid/pixel stream of edge magnitudes, which has no backpressure. Packs pixels four-per-word in raster order and writes them to a word-addressed frame buffer through a simple req/ready write port. A small word FIFO absorbs memory stalls; the block tracks the output frame extent ((W-2)x(H-2)) and signals frame completion.

Parameters:
- MAX_WIDTH, 4096, maximum input image width; sets the image_width port width.
- ADDR_W, 20, memory word-address width.
- FIFO_DEPTH, 8, word FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; arms a frame (honoured only in IDLE)
- image_width  in  $clog2(MAX_WIDTH)  input image width W, sampled at start
- image_height  in  16  input image height H, sampled at start
- base_addr  in  ADDR_W  first word address, sampled at start
- pix_valid  in  1  Sobel output valid
- pix_data  in  8  Sobel output pixel
- mem_req  out  1  write request (FIFO not empty)
- mem_addr  out  ADDR_W  word address of head entry
- mem_wdata  out  32  packed pixels; first pixel in byte 0
- mem_be  out  4  byte enables of head entry
- mem_ready  in  1  write accepted when mem_req && mem_ready
- busy  out  1  high in RUN and FLUSH
- frame_done  out  1  one-cycle pulse at frame completion
- overflow  out  1  sticky; a word was dropped because the FIFO was full

Behaviour:
- Reset (rst=0 at a clk edge) forces state IDLE, empties the FIFO, and clears the packer and counters. All outputs are 0: mem_req, mem_addr, mem_wdata, mem_be, busy, frame_done, overflow.
- Reset mid-frame aborts the frame. Nothing is flushed and no frame_done is produced.
- Frame size: N = (W-2)*(H-2) in 28-bit unsigned arithmetic. If W<3 or H<3, N=0.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start, with N>0. Clears overflow, loads the address counter from base_addr, and zeroes the pixel count.
  - IDLE -> DONE on start with N=0.
  - RUN -> FLUSH on the edge that accepts pixel N.
  - FLUSH -> DONE when the FIFO is empty and the packer is empty.
  - DONE -> IDLE unconditionally after one cycle. frame_done=1 only in DONE.
- Pixels are accepted only in RUN when pix_valid=1. pix_valid is ignored in IDLE, FLUSH and DONE. start is ignored outside IDLE.
- Packer:
  - Byte lane = pixel count mod 4.
  - After lane 3 is written, the full word (be=4'hF) is pushed to the FIFO on that same edge.
  - On the edge accepting pixel N with a partial word, that word is pushed with be = lanes filled (e.g. 4'b0001). Unused bytes are 0.
- Each pushed entry carries its address. The address counter increments per push and wraps modulo 2^ADDR_W.
- FIFO is show-ahead. mem_req/mem_addr/mem_wdata/mem_be are registered head state, so mem_req rises the cycle after the push edge. A pop occurs on mem_req && mem_ready.
- When mem_req=0, the data outputs hold their last values.
- Push when full:
  - With a pop on the same edge, the push succeeds and there is no overflow.
  - With no pop, the word is dropped, overflow is set, and the address counter still increments so later words keep correct addresses.
- busy = state in {RUN, FLUSH}.

Optional Feature:
- Macro SOBEL_WRITER_THRESH_EN.
- Defined: adds input port threshold[7:0], sampled at start. Each accepted pixel is stored as 8'hFF if pix_data >= threshold, else 8'h00.
- Undefined: no threshold port; pix_data is stored unchanged.

Decomposition:
- Package sobel_pkg holds:
  - MEM_DATA_W=32, BYTES_PER_WORD=4, BE_W=4
  - writer state enum (IDLE/RUN/FLUSH/DONE)
  - FIFO entry struct (addr, data, be)
- One sub-module: sobel_wr_fifo. Synchronous show-ahead FIFO, parameterised on depth and entry width, with full/empty flags and simultaneous push/pop.

Test Plan:
- W=6, H=6, base=0x100, mem_ready=1, pixels 0x00..0x0F -> 4 writes at 0x100..0x103: data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, be 4'hF; one frame_done pulse; overflow=0.
- W=5, H=5 (N=9), pixels 0x00..0x08 -> writes 0x03020100, 0x07060504, then 0x00000008 with be 4'b0001; frame_done after the third write.
- W=10, H=10 (N=64, 16 words), FIFO_DEPTH=8, mem_ready=0 during the stream, then 1 -> overflow=1; exactly 8 writes at base..base+7; frame_done asserted; 9th..16th words absent.
- FIFO full with mem_ready=1 on the same edge a 9th word is pushed -> no overflow; all 16 writes in ascending address order.
- rst=0 for one cycle after 5 pixels accepted -> next cycle mem_req=0, busy=0, no frame_done; a new start with W=6, H=6 then completes normally from base.
- start with W=2, H=100 -> no mem_req; frame_done high on the second cycle after start; start pulsed during RUN of a normal frame is ignored.
